// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle instruction-sequencing FSM
// Optional memory-wait watchdog enabled by defining MULTICYCLE_SEQUENCER_WATCHDOG_EN.
module multicycle_sequencer #(
  parameter int unsigned WD_LIMIT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic       i_branch_taken,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_mem_sel,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic       o_alu_src,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_src,
  output logic [2:0] o_mem_to_reg,
  output logic [2:0] o_state,
  output logic       o_instret,
  output logic       o_trap,
  output logic [1:0] o_trap_cause
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CL_NONE, CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC
  } cls_e;

  state_e     r_state, w_next_state;
  cls_e       r_cls, w_dec_cls;
  logic       r_trap;
  logic [1:0] r_cause, w_next_cause;
  logic       w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_reg_write, w_instret;
  logic       w_wd_expire;

`ifdef MULTICYCLE_SEQUENCER_WATCHDOG_EN
  localparam logic [7:0] LP_WD_LAST = 8'(WD_LIMIT - 1);
  logic [7:0] r_wd_cnt;
  logic       w_waiting;

  assign w_waiting   = (r_state == ST_FETCH) || (r_state == ST_MEM);
  // Expire in the cycle the count would reach WD_LIMIT; a mem_ready in that cycle still wins.
  assign w_wd_expire = w_waiting && !i_mem_ready && (r_wd_cnt == LP_WD_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || (w_next_state != r_state)) begin
      r_wd_cnt <= 8'd0;
    end else if (w_waiting && !i_mem_ready) begin
      r_wd_cnt <= r_wd_cnt + 8'd1;
    end
  end
`else
  logic w_unused_wd;
  assign w_unused_wd = |WD_LIMIT;
  assign w_wd_expire = 1'b0;
`endif

  always_comb begin
    w_dec_cls = CL_NONE;
    case (i_opcode)
      7'd51:   w_dec_cls = CL_R;
      7'd19:   w_dec_cls = CL_I;
      7'd3:    w_dec_cls = CL_LOAD;
      7'd35:   w_dec_cls = CL_STORE;
      7'd99:   w_dec_cls = CL_BRANCH;
      7'd111:  w_dec_cls = CL_JAL;
      7'd103:  w_dec_cls = CL_JALR;
      7'd55:   w_dec_cls = CL_LUI;
      7'd23:   w_dec_cls = CL_AUIPC;
      default: w_dec_cls = CL_NONE;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cause = r_cause;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_instret    = 1'b0;
    o_mem_sel    = 1'b0;
    o_alu_src    = 1'b0;
    o_alu_op     = 2'b00;
    o_pc_src     = 2'b00;
    o_mem_to_reg = 3'b000;
    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        if (i_mem_ready) begin
          w_ir_write   = 1'b1;
          w_next_state = ST_DECODE;
        end else if (w_wd_expire) begin
          w_next_state = ST_TRAP;
          w_next_cause = 2'b10;
        end
      end
      ST_DECODE: begin
        if (w_dec_cls == CL_NONE) begin
          w_next_state = ST_TRAP;
          w_next_cause = 2'b01;
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_next_state = ST_WB;
        case (r_cls)
          CL_R:      o_alu_op = 2'b11;
          CL_I:      begin o_alu_src = 1'b1; o_alu_op = 2'b10; end
          CL_LOAD,
          CL_STORE:  begin o_alu_src = 1'b1; w_next_state = ST_MEM; end
          CL_BRANCH: begin
            o_alu_op     = 2'b01;
            w_pc_write   = 1'b1;
            o_pc_src     = i_branch_taken ? 2'b01 : 2'b00;
            w_instret    = 1'b1;
            w_next_state = ST_FETCH;
          end
          CL_JALR:   o_alu_src = 1'b1;
          default:   o_alu_op = 2'b00;
        endcase
      end
      ST_MEM: begin
        w_mem_req = 1'b1;
        o_mem_sel = 1'b1;
        w_mem_we  = (r_cls == CL_STORE);
        o_alu_src = 1'b1;
        if (i_mem_ready) begin
          if (r_cls == CL_STORE) begin
            w_pc_write   = 1'b1;
            w_instret    = 1'b1;
            w_next_state = ST_FETCH;
          end else begin
            w_next_state = ST_WB;
          end
        end else if (w_wd_expire) begin
          w_next_state = ST_TRAP;
          w_next_cause = 2'b10;
        end
      end
      ST_WB: begin
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        w_instret    = 1'b1;
        w_next_state = ST_FETCH;
        case (r_cls)
          CL_LOAD:  o_mem_to_reg = 3'b001;
          CL_JAL:   begin o_mem_to_reg = 3'b010; o_pc_src = 2'b10; end
          CL_JALR:  begin o_mem_to_reg = 3'b010; o_pc_src = 2'b11; end
          CL_LUI:   o_mem_to_reg = 3'b011;
          CL_AUIPC: o_mem_to_reg = 3'b100;
          default:  o_mem_to_reg = 3'b000;
        endcase
      end
      ST_TRAP: w_next_state = ST_TRAP;
      default: begin
        w_next_state = ST_TRAP;
        w_next_cause = 2'b01;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_FETCH;
      r_cls   <= CL_NONE;
      r_trap  <= 1'b0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_next_state;
      r_cause <= w_next_cause;
      r_trap  <= r_trap | (w_next_state == ST_TRAP);
      if (r_state == ST_DECODE) begin
        r_cls <= w_dec_cls;
      end
    end
  end

  // Reset abandons any transaction: side-effecting strobes drop in the same cycle.
  assign o_mem_req    = w_mem_req   & ~i_rst;
  assign o_mem_we     = w_mem_we    & ~i_rst;
  assign o_ir_write   = w_ir_write  & ~i_rst;
  assign o_pc_write   = w_pc_write  & ~i_rst;
  assign o_reg_write  = w_reg_write & ~i_rst;
  assign o_instret    = w_instret   & ~i_rst;
  assign o_state      = r_state;
  assign o_trap       = r_trap;
  assign o_trap_cause = r_cause;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       i_rst, i_branch_taken, i_mem_ready;
  logic [6:0] i_opcode;
  logic       o_mem_req, o_mem_we, o_mem_sel, o_ir_write, o_pc_write, o_reg_write, o_alu_src;
  logic [1:0] o_alu_op, o_pc_src, o_trap_cause;
  logic [2:0] o_mem_to_reg, o_state;
  logic       o_instret, o_trap;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         lat;
    logic [3:0] wb;
    logic [2:0] pc;
    logic [2:0] alu;
  } exp_t;

  exp_t sb_q[$];

  multicycle_sequencer #(.WD_LIMIT(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_branch_taken(i_branch_taken),
    .i_mem_ready(i_mem_ready), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_sel(o_mem_sel), .o_ir_write(o_ir_write), .o_pc_write(o_pc_write),
    .o_reg_write(o_reg_write), .o_alu_src(o_alu_src), .o_alu_op(o_alu_op),
    .o_pc_src(o_pc_src), .o_mem_to_reg(o_mem_to_reg), .o_state(o_state),
    .o_instret(o_instret), .o_trap(o_trap), .o_trap_cause(o_trap_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [6:0] op, input logic tk, input int fw, input int mw);
    exp_t e;
    e.lat = 4; e.wb = 4'b1_000; e.pc = 3'b1_00; e.alu = 3'b0_00;
    case (op)
      7'd51:  e.alu = 3'b0_11;
      7'd19:  e.alu = 3'b1_10;
      7'd3:   begin e.lat = 5 + mw; e.alu = 3'b1_00; e.wb = 4'b1_001; end
      7'd35:  begin e.lat = 4 + mw; e.alu = 3'b1_00; e.wb = 4'b0_000; end
      7'd99:  begin e.lat = 3; e.alu = 3'b0_01; e.wb = 4'b0_000; e.pc = tk ? 3'b1_01 : 3'b1_00; end
      7'd111: begin e.wb = 4'b1_010; e.pc = 3'b1_10; end
      7'd103: begin e.alu = 3'b1_00; e.wb = 4'b1_010; e.pc = 3'b1_11; end
      7'd55:  e.wb = 4'b1_011;
      7'd23:  e.wb = 4'b1_100;
      default: e.lat = 0;
    endcase
    e.lat += fw;
    return e;
  endfunction

  // Entered at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [6:0] op, input logic tk, input int fw, input int mw);
    exp_t e;
    logic [2:0] st;
    logic [2:0] prev_st = 3'd6;
    int wcnt = 0, ir_cyc = -1, dmem_cyc = 0, we_cyc = 0;
    bit done = 0, rw_seen = 0, alu_done = 0;
    sb_q.push_back(model(op, tk, fw, mw));
    for (int c = 1; c <= 60 && !done; c++) begin
      i_opcode = op;
      i_branch_taken = tk;
      st = o_state;
      if (st != prev_st) wcnt = 0;
      if (st == 3'd0)      i_mem_ready = (wcnt == fw);
      else if (st == 3'd3) i_mem_ready = (wcnt == mw);
      else                 i_mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (o_ir_write) ir_cyc = c;
      if (o_mem_req && o_mem_sel) dmem_cyc++;
      if (o_mem_we) we_cyc++;
      if (o_reg_write) rw_seen = 1;
      if (st == 3'd2 && !alu_done) begin
        alu_done = 1;
        chk($sformatf("alu_op%0d", op), 32'({o_alu_src, o_alu_op}), 32'(sb_q[0].alu));
      end
      if (o_instret) begin
        e = sb_q.pop_front();
        done = 1;
        chk($sformatf("lat_op%0d", op), 32'(c), 32'(e.lat));
        chk($sformatf("wb_op%0d", op), 32'({o_reg_write, o_mem_to_reg}), 32'(e.wb));
        chk($sformatf("pc_op%0d", op), 32'({o_pc_write, o_pc_src}), 32'(e.pc));
      end
      if (o_mem_req && !i_mem_ready) wcnt++;
      prev_st = st;
      @(posedge clk); #1;
    end
    i_mem_ready = 1'b0;
    if (!done) begin
      chk($sformatf("timeout_op%0d", op), 32'(0), 32'(1));
      void'(sb_q.pop_front());
    end
    chk($sformatf("ir_cyc_op%0d", op), 32'(ir_cyc), 32'(fw + 1));
    chk($sformatf("state_after_op%0d", op), 32'(o_state), 32'(0));
    if (op == 7'd3 || op == 7'd35) chk($sformatf("dmem_cyc_op%0d", op), 32'(dmem_cyc), 32'(mw + 1));
    if (op == 7'd35) chk("store_we_cyc", 32'(we_cyc), 32'(mw + 1));
    if (op == 7'd3) chk("load_we_cyc", 32'(we_cyc), 32'(0));
    if (op == 7'd99) chk("branch_no_regwr", 32'(rw_seen), 32'(0));
  endtask

  // Entered at posedge+1; returns at posedge+2 in the first FETCH cycle after release.
  task automatic do_reset();
    i_rst = 1'b1;
    i_mem_ready = 1'b0;
    #1;
    chk("rst_mem_req_forced", 32'(o_mem_req), 32'(0));
    @(posedge clk); #1;
    chk("rst_state", 32'(o_state), 32'(0));
    chk("rst_trap", 32'({o_trap, o_trap_cause}), 32'(0));
    i_rst = 1'b0;
    #1;
    chk("post_rst_mem_req", 32'({o_mem_req, o_mem_sel}), 32'(2'b10));
  endtask

  initial begin
    int cnt;
    logic [6:0] ill [2];
    i_rst = 1'b1; i_opcode = 7'd0; i_branch_taken = 1'b0; i_mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    run_instr(7'd19,  1'b0, 0, 0);
    run_instr(7'd3,   1'b0, 0, 3);
    run_instr(7'd99,  1'b1, 0, 0);
    run_instr(7'd99,  1'b0, 1, 0);
    run_instr(7'd51,  1'b0, 2, 0);
    run_instr(7'd35,  1'b0, 0, 1);
    run_instr(7'd111, 1'b0, 0, 0);
    run_instr(7'd103, 1'b0, 1, 0);
    run_instr(7'd55,  1'b0, 0, 0);
    run_instr(7'd23,  1'b0, 0, 0);
    run_instr(7'd3,   1'b0, 1, 0);
    run_instr(7'd35,  1'b0, 2, 2);

    // Illegal opcodes trap right after DECODE and stay halted.
    ill[0] = 7'h7F; ill[1] = 7'd20;
    for (int k = 0; k < 2; k++) begin
      i_opcode = ill[k];
      i_mem_ready = 1'b1;
      @(posedge clk); #1;
      i_mem_ready = 1'b0;
      chk("ill_decode", 32'(o_state), 32'(1));
      @(posedge clk); #1;
      chk("ill_trap_state", 32'(o_state), 32'(7));
      chk("ill_trap_cause", 32'({o_trap, o_trap_cause}), 32'(3'b1_01));
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
        i_mem_ready = 1'($urandom_range(0, 1));
        #1;
        if (o_mem_req || o_instret || o_pc_write) cnt++;
        @(posedge clk); #1;
      end
      chk("ill_no_req", 32'(cnt), 32'(0));
      chk("ill_trap_held", 32'({o_state, o_trap, o_trap_cause}), 32'({3'd7, 3'b1_01}));
      do_reset();
    end

    // Reset in the middle of a store's MEM wait.
    i_opcode = 7'd35;
    cnt = 0;
    for (int c = 0; c < 10 && o_state != 3'd3; c++) begin
      i_mem_ready = (o_state == 3'd0);
      #1;
      if (o_instret) cnt++;
      @(posedge clk); #1;
    end
    i_mem_ready = 1'b0;
    #1;
    chk("mid_store_we", 32'({o_state, o_mem_we}), 32'({3'd3, 1'b1}));
    i_rst = 1'b1;
    #1;
    chk("mid_store_rst_strobes", 32'({o_mem_we, o_mem_req, o_instret}), 32'(0));
    @(posedge clk); #1;
    chk("mid_store_rst_state", 32'(o_state), 32'(0));
    i_rst = 1'b0;
    #1;
    chk("mid_store_no_instret", 32'(cnt), 32'(0));
    chk("mid_store_restart", 32'(o_mem_req), 32'(1));

`ifdef MULTICYCLE_SEQUENCER_WATCHDOG_EN
    for (int c = 0; c < 4; c++) begin
      chk("wd_waiting", 32'(o_state), 32'(0));
      @(posedge clk); #1;
    end
    chk("wd_trap", 32'({o_state, o_trap, o_trap_cause}), 32'({3'd7, 3'b1_10}));
`else
    cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      if (!o_mem_req || o_mem_sel || o_mem_we || o_trap || o_state != 3'd0) cnt++;
      @(posedge clk); #1;
    end
    chk("no_wd_trap", 32'(cnt), 32'(0));
    chk("no_wd_cause", 32'({o_trap, o_trap_cause}), 32'(0));
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter: WD_LIMIT, default 255, memory-wait cycle limit before watchdog trap (8-bit, 1..255); used only when WATCHDOG_EN is defined.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  instruction opcode field from the instruction register; sampled in DECODE only.
REQ-005 branch_taken  input  1  branch comparison result from the datapath; valid in EXEC.
REQ-006 mem_ready  input  1  shared memory completion strobe, one cycle.
REQ-007 mem_req, mem_we, mem_sel  output  1 each  memory request; write enable; port select (0 = instruction, 1 = data).
REQ-008 ir_write, pc_write, reg_write, alu_src  output  1 each  datapath strobes and ALU operand select.
REQ-009 alu_op, pc_src  output  2 each  ALU control class; PC source (00 = pc+4, 01 = branch, 10 = jal, 11 = jalr).
REQ-010 mem_to_reg  output  3  write-back select (000 = alu, 001 = mem, 010 = pc+4, 011 = u-imm, 100 = pc+u-imm).
REQ-011 state  output  3  current state, for debug.
REQ-012 instret  output  1  one-cycle pulse per retired instruction.
REQ-013 trap, trap_cause  output  1 / 2  sticky halt flag; cause (01 = illegal opcode, 10 = watchdog).

Function
REQ-014 States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7; codes 5 and 6 SHALL go to TRAP with cause 01.
REQ-015 FETCH: mem_req = 1, mem_sel = 0, mem_we = 0, held until mem_ready; in the mem_ready cycle ir_write = 1 for that cycle only, then DECODE.
REQ-016 DECODE: register the opcode into an internal class register. Legal opcodes are 51, 19, 3, 35, 99, 111, 103, 55 and 23; these go to EXEC. Any other opcode goes to TRAP with cause 01.
REQ-017 EXEC: alu_src / alu_op per class: R 0/11, I 1/10, load 1/00, store 1/00, branch 0/01, jal 0/00, jalr 1/00, lui and auipc 0/00.
REQ-018 EXEC branch: pc_write = 1, pc_src = branch_taken ? 01 : 00, instret = 1, next state FETCH. Load and store go to MEM. All other classes go to WB.
REQ-019 MEM: mem_req = 1, mem_sel = 1, mem_we = 1 for store only, alu_src = 1, alu_op = 00, held until mem_ready. On mem_ready, store: pc_write = 1, pc_src = 00, instret = 1, next state FETCH. Load: next state WB.
REQ-020 WB: reg_write = 1 and mem_to_reg per class (R/I 000, load 001, jal/jalr 010, lui 011, auipc 100). pc_write = 1 with pc_src 10 for jal, 11 for jalr, 00 otherwise; instret = 1; next state FETCH.
REQ-021 Latency in cycles, with zero memory wait: R/I/lui/auipc/jal/jalr = 4; branch = 3; store = 4; load = 5. Each mem_ready wait cycle adds 1.
REQ-022 mem_req, mem_we and mem_sel SHALL stay stable while waiting; mem_ready outside FETCH/MEM SHALL be ignored.
REQ-023 Outputs not listed for a state SHALL be 0.
REQ-024 TRAP: all strobes 0, trap = 1, trap_cause held; remain in TRAP until rst.

Reset
REQ-025 rst high at a clock edge: state <= FETCH, trap <= 0, trap_cause <= 00, class register and watchdog counter cleared.
REQ-026 While rst is high, mem_req, ir_write, pc_write, reg_write, mem_we and instret SHALL be forced 0 combinationally. Any transaction in progress is abandoned.
REQ-027 The first cycle after rst deasserts SHALL be FETCH with mem_req = 1.

Configuration
REQ-028 Macro MULTICYCLE_SEQUENCER_WATCHDOG_EN defined: an 8-bit counter increments each FETCH/MEM cycle with mem_ready = 0 and clears on every state change. When the count reaches WD_LIMIT without mem_ready, next state is TRAP with cause 10. A mem_ready arriving in the limit cycle SHALL win.
REQ-029 Macro undefined: no counter is present, the sequencer waits for mem_ready indefinitely, and trap_cause never equals 10.

Verification
REQ-030 addi (opcode 19), mem_ready immediate -> ir_write at cycle 1, reg_write = 1 and mem_to_reg = 000 at cycle 4, instret pulse, back to FETCH.
REQ-031 lw (opcode 3), data mem_ready delayed 3 cycles -> mem_req = 1 and mem_sel = 1 held 4 cycles, then WB with mem_to_reg = 001; total 8 cycles.
REQ-032 beq (opcode 99) with branch_taken = 1 -> pc_write = 1 and pc_src = 01 in EXEC; with branch_taken = 0 -> pc_src = 00; reg_write never asserted.
REQ-033 Opcode 0x7F -> TRAP in the cycle after DECODE; trap = 1, trap_cause = 01, no mem_req for 20 cycles; rst clears trap and restarts FETCH.
REQ-034 rst asserted mid-MEM on a store -> mem_we = 0 immediately; state = FETCH after the edge; no instret pulse.
REQ-035 With WATCHDOG_EN and WD_LIMIT = 4, mem_ready held low in FETCH -> TRAP after 4 wait cycles, trap_cause = 10. Without the macro, no trap after 1000 cycles.
